// File: rtl/nbit_parity_checker.sv
// Receive side of the N-bit parity link: deserialises start/data/parity/stop
// frames into a parallel word and flags parity and framing errors.
module nbit_parity_checker #(
  parameter int N_Bits     = 6,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SerialIn,
  input  logic              BitValid,
  output logic [N_Bits-1:0] DataOutput,
  output logic              FrameValid,
  output logic              ParityError,
  output logic              FrameError,
  output logic              Busy
);

  localparam int CntW = $clog2(N_Bits) + 1;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } stateType;

  stateType            state;
  stateType            nextState;
  logic [CntW-1:0]     bitCount;
  logic [N_Bits-1:0]   shiftReg;
  logic                rxParity;

  // NOTE: nextState gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nextState = state;
    if (BitValid) begin
      unique case (state)
        IDLE:    if (!SerialIn) nextState = DATA;
        DATA:    if (bitCount == CntW'(N_Bits - 1)) nextState = PARITY;
        PARITY:  nextState = STOP;
        STOP:    nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bitCount    <= '0;
      shiftReg    <= '0;
      rxParity    <= 1'b0;
      DataOutput  <= '0;
      FrameValid  <= 1'b0;
      ParityError <= 1'b0;
      FrameError  <= 1'b0;
    end else begin
      state      <= nextState;
      FrameValid <= 1'b0;
      if (BitValid) begin
        unique case (state)
          IDLE: bitCount <= '0;
          DATA: begin
            // Decoded write avoids an over-wide bit-select index.
            for (int i = 0; i < N_Bits; i++) begin
              if (bitCount == CntW'(i)) shiftReg[i] <= SerialIn;
            end
            bitCount <= bitCount + CntW'(1);
          end
          PARITY: rxParity <= SerialIn;
          STOP: begin
            DataOutput  <= shiftReg;
            ParityError <= rxParity != ((^shiftReg) ^ ODD_PARITY);
            FrameError  <= ~SerialIn;
            FrameValid  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_nbit_parity_checker.sv
// Self-checking bench: drives one serial line into an even- and an odd-parity
// checker and scores each delivered frame against a queued reference result.
module tb_nbit_parity_checker;

  localparam int NB = 6;

  typedef struct packed {
    logic [NB-1:0] data;
    logic          perr;
    logic          ferr;
  } frameType;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          SerialIn = 1'b1;
  logic          BitValid = 1'b0;
  logic [NB-1:0] dataEven, dataOdd;
  logic          fvEven, fvOdd, perrEven, perrOdd, ferrEven, ferrOdd, busyEven, busyOdd;

  frameType expEven[$];
  frameType expOdd[$];
  frameType gotEven, gotOdd, wantEven, wantOdd;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nbit_parity_checker #(.N_Bits(NB), .ODD_PARITY(1'b0)) dutEven (
    .clk(clk), .rst(rst), .SerialIn(SerialIn), .BitValid(BitValid),
    .DataOutput(dataEven), .FrameValid(fvEven), .ParityError(perrEven),
    .FrameError(ferrEven), .Busy(busyEven)
  );

  nbit_parity_checker #(.N_Bits(NB), .ODD_PARITY(1'b1)) dutOdd (
    .clk(clk), .rst(rst), .SerialIn(SerialIn), .BitValid(BitValid),
    .DataOutput(dataOdd), .FrameValid(fvOdd), .ParityError(perrOdd),
    .FrameError(ferrOdd), .Busy(busyOdd)
  );

  // Scoreboard: every FrameValid pulse consumes exactly one expected frame.
  always @(negedge clk) begin
    if (fvEven !== 1'b0) begin
      checks++;
      gotEven = {dataEven, perrEven, ferrEven};
      if (expEven.size() == 0) begin
        failures++;
        $display("FAIL even_unexpected_frame got=%b FrameValid=%b", gotEven, fvEven);
      end else begin
        wantEven = expEven.pop_front();
        if (gotEven !== wantEven) begin
          failures++;
          $display("FAIL even_frame got data=%b perr=%b ferr=%b want data=%b perr=%b ferr=%b",
                   gotEven.data, gotEven.perr, gotEven.ferr,
                   wantEven.data, wantEven.perr, wantEven.ferr);
        end
      end
    end
    if (fvOdd !== 1'b0) begin
      checks++;
      gotOdd = {dataOdd, perrOdd, ferrOdd};
      if (expOdd.size() == 0) begin
        failures++;
        $display("FAIL odd_unexpected_frame got=%b FrameValid=%b", gotOdd, fvOdd);
      end else begin
        wantOdd = expOdd.pop_front();
        if (gotOdd !== wantOdd) begin
          failures++;
          $display("FAIL odd_frame got data=%b perr=%b ferr=%b want data=%b perr=%b ferr=%b",
                   gotOdd.data, gotOdd.perr, gotOdd.ferr,
                   wantOdd.data, wantOdd.perr, wantOdd.ferr);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One line bit, followed by `gap` idle cycles; Busy must stay high across gaps.
  task automatic sendBit(input logic b, input int gap, input bit checkBusy);
    SerialIn = b;
    BitValid = 1'b1;
    @(posedge clk); #1;
    BitValid = 1'b0;
    SerialIn = ~b;
    repeat (gap) begin
      if (checkBusy) begin
        checks++;
        if ({busyEven, busyOdd} !== 2'b11) begin
          failures++;
          $display("FAIL busy_in_gap got=%b want=11", {busyEven, busyOdd});
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic sendFrame(input logic [NB-1:0] d, input logic par, input logic stop,
                           input int gap);
    frameType fe, fo;
    fe.data = d; fe.perr = (par != (^d));  fe.ferr = ~stop;
    fo.data = d; fo.perr = (par != ~(^d)); fo.ferr = ~stop;
    sendBit(1'b0, gap, 1'b1);
    for (int i = 0; i < NB; i++) sendBit(d[i], gap, 1'b1);
    sendBit(par, gap, 1'b1);
    expEven.push_back(fe);
    expOdd.push_back(fo);
    SerialIn = stop;
    BitValid = 1'b1;
    @(posedge clk); #1;
    BitValid = 1'b0;
    SerialIn = 1'b1;
    checks++;
    if ({fvEven, fvOdd, busyEven, busyOdd} !== 4'b1100) begin
      failures++;
      $display("FAIL stop_edge_latency got fv=%b%b busy=%b%b want fv=11 busy=00",
               fvEven, fvOdd, busyEven, busyOdd);
    end
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic checkAllZero(input string name);
    checks++;
    if ({dataEven, dataOdd, fvEven, fvOdd, perrEven, perrOdd, ferrEven, ferrOdd,
         busyEven, busyOdd} !== '0) begin
      failures++;
      $display("FAIL %s got data=%b/%b fv=%b%b perr=%b%b ferr=%b%b busy=%b%b want all 0",
               name, dataEven, dataOdd, fvEven, fvOdd, perrEven, perrOdd,
               ferrEven, ferrOdd, busyEven, busyOdd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    BitValid = 1'b0;
    SerialIn = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checkAllZero("reset_state");
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_good();
    sendFrame(6'b101101, 1'b0, 1'b1, 0);
    // Outputs must hold while the line is idle and BitValid is low.
    repeat (3) begin
      SerialIn = ~SerialIn;
      @(posedge clk); #1;
    end
    SerialIn = 1'b1;
    checks++;
    if ({dataEven, perrEven, ferrEven, fvEven, busyEven} !== {6'b101101, 4'b0000}) begin
      failures++;
      $display("FAIL hold_after_frame got data=%b perr=%b ferr=%b fv=%b busy=%b want 101101 0 0 0 0",
               dataEven, perrEven, ferrEven, fvEven, busyEven);
    end
  endtask

  task automatic test_parity_error();
    sendFrame(6'b101101, 1'b1, 1'b1, 0);
    @(posedge clk); #1;
  endtask

  task automatic test_framing_error();
    sendFrame(6'b000111, 1'b1, 1'b0, 0);
    @(posedge clk); #1;
  endtask

  task automatic test_gapped();
    sendFrame(6'b110010, 1'b1, 1'b1, 3);
  endtask

  task automatic test_reset_mid_frame();
    logic [NB-1:0] partial;
    partial = 6'b111101;
    sendBit(1'b0, 0, 1'b0);
    for (int i = 0; i < 3; i++) sendBit(partial[i], 0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    checkAllZero("reset_mid_frame");
    rst = 1'b0;
    // Remaining bits of the aborted frame must not produce a frame.
    for (int i = 3; i < NB; i++) sendBit(partial[i], 0, 1'b0);
    sendBit(1'b1, 2, 1'b0);
    checks++;
    if ({busyEven, busyOdd} !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_abort got busy=%b%b want 00", busyEven, busyOdd);
    end
    sendFrame(6'b011110, 1'b0, 1'b1, 0);
  endtask

  task automatic test_back_to_back();
    sendFrame(6'b000001, 1'b0, 1'b1, 0);
    sendFrame(6'b111111, 1'b1, 1'b1, 0);
  endtask

  task automatic test_random();
    logic [NB-1:0] d;
    logic par;
    logic stop;
    for (int n = 0; n < 30; n++) begin
      d    = NB'($urandom);
      par  = (^d) ^ ($urandom_range(0, 3) == 0);
      stop = ($urandom_range(0, 4) != 0);
      sendFrame(d, par, stop, $urandom_range(0, 2));
    end
  endtask

  task automatic test_drain();
    int waited = 0;
    while ((expEven.size() != 0 || expOdd.size() != 0) && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (expEven.size() != 0 || expOdd.size() != 0) begin
      failures++;
      $display("FAIL frames_outstanding got even=%0d odd=%0d want 0 0",
               expEven.size(), expOdd.size());
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_parity_error();
    test_framing_error();
    test_gapped();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    test_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
